// File: rtl/apb_ss_guard_pkg.sv
// Shared types and constants for the APB subsystem guard.
package apb_ss_guard_pkg;

  typedef enum logic [1:0] {
    BLOCK = 2'd0,
    PASS  = 2'd1,
    FAULT = 2'd2
  } guard_state_e;

  localparam int unsigned SS_CTRL_EN_BIT  = 0;
  localparam int unsigned SS_CTRL_CLR_BIT = 1;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADC_0DE5;

endpackage

// File: rtl/apb_ss_guard.sv
// APB guard between the interconnect and one student subsystem: forwards
// transfers while enabled, answers with PSLVERR while disabled or faulted,
// and aborts transfers whose access phase stalls for TIMEOUT_CYC cycles.
module apb_ss_guard
  import apb_ss_guard_pkg::*;
#(
  parameter int unsigned        APB_AW      = 32,
  parameter int unsigned        APB_DW      = 32,
  parameter int unsigned        SS_CTRL_W   = 7,
  parameter int unsigned        TIMEOUT_CYC = 16,
  parameter logic [APB_DW-1:0]  ERR_RDATA   = ERR_RDATA_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // upstream (from interconnect)
  input  logic [APB_AW-1:0]     S_APB_PADDR,
  input  logic                  S_APB_PSEL,
  input  logic                  S_APB_PENABLE,
  input  logic                  S_APB_PWRITE,
  input  logic [APB_DW-1:0]     S_APB_PWDATA,
  input  logic [APB_DW/8-1:0]   S_APB_PSTRB,
  output logic [APB_DW-1:0]     S_APB_PRDATA,
  output logic                  S_APB_PREADY,
  output logic                  S_APB_PSLVERR,
  // downstream (to subsystem)
  output logic [APB_AW-1:0]     M_APB_PADDR,
  output logic                  M_APB_PSEL,
  output logic                  M_APB_PENABLE,
  output logic                  M_APB_PWRITE,
  output logic [APB_DW-1:0]     M_APB_PWDATA,
  output logic [APB_DW/8-1:0]   M_APB_PSTRB,
  input  logic [APB_DW-1:0]     M_APB_PRDATA,
  input  logic                  M_APB_PREADY,
  input  logic                  M_APB_PSLVERR,
  // control / status
  input  logic [SS_CTRL_W-1:0]  ss_ctrl_i,
  output logic                  fault_o,
  output logic                  irq_o,
  output logic [APB_AW-1:0]     fault_addr_o,
  output logic [7:0]            fault_cnt_o
);

  localparam int unsigned WCW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYC - 1);

  guard_state_e      r_state;
  guard_state_e      w_state_nxt;
  logic [WCW-1:0]    r_wait_cnt;
  logic              r_fault;
  logic              r_irq;
  logic [APB_AW-1:0] r_fault_addr;
  logic [7:0]        r_fault_cnt;

  logic w_en;
  logic w_clr;
  logic w_access;
  logic w_stall;
  logic w_timeout;
  logic w_boundary;
  logic w_unused_ctrl;

  assign w_en          = ss_ctrl_i[SS_CTRL_EN_BIT];
  assign w_clr         = ss_ctrl_i[SS_CTRL_CLR_BIT];
  // Only the enable and clear bits carry meaning.
  assign w_unused_ctrl = ^ss_ctrl_i;

  assign w_access  = S_APB_PSEL && S_APB_PENABLE;
  assign w_stall   = (r_state == PASS) && w_access && !M_APB_PREADY;
  assign w_timeout = w_stall && (r_wait_cnt == WAIT_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= BLOCK;
    else          r_state <= w_state_nxt;
  end

  // Bus routing, guard-generated responses and next-state selection.
  always_comb begin
    M_APB_PADDR   = '0;
    M_APB_PSEL    = 1'b0;
    M_APB_PENABLE = 1'b0;
    M_APB_PWRITE  = 1'b0;
    M_APB_PWDATA  = '0;
    M_APB_PSTRB   = '0;
    S_APB_PRDATA  = '0;
    S_APB_PREADY  = 1'b0;
    S_APB_PSLVERR = 1'b0;
    w_state_nxt   = r_state;

    unique case (r_state)
      PASS: begin
        M_APB_PADDR   = S_APB_PADDR;
        M_APB_PSEL    = S_APB_PSEL;
        M_APB_PENABLE = S_APB_PENABLE;
        M_APB_PWRITE  = S_APB_PWRITE;
        M_APB_PWDATA  = S_APB_PWDATA;
        M_APB_PSTRB   = S_APB_PSTRB;
        if (S_APB_PSEL) begin
          S_APB_PRDATA  = M_APB_PRDATA;
          S_APB_PREADY  = M_APB_PREADY;
          S_APB_PSLVERR = M_APB_PSLVERR;
        end
        // Abort: release the subsystem and complete upstream with an error.
        if (w_timeout) begin
          M_APB_PSEL    = 1'b0;
          M_APB_PENABLE = 1'b0;
          S_APB_PRDATA  = ERR_RDATA;
          S_APB_PREADY  = 1'b1;
          S_APB_PSLVERR = 1'b1;
        end
      end
      BLOCK, FAULT: begin
        if (w_access) begin
          S_APB_PRDATA  = ERR_RDATA;
          S_APB_PREADY  = 1'b1;
          S_APB_PSLVERR = 1'b1;
        end
      end
      default: ;
    endcase

    w_boundary = !S_APB_PSEL || (S_APB_PENABLE && S_APB_PREADY);

    unique case (r_state)
      BLOCK: if (w_boundary && w_en) w_state_nxt = PASS;
      PASS: begin
        if (w_timeout)                  w_state_nxt = FAULT;
        else if (w_boundary && !w_en)   w_state_nxt = BLOCK;
      end
      FAULT: if (w_boundary && w_clr) w_state_nxt = w_en ? PASS : BLOCK;
      default: w_state_nxt = BLOCK;
    endcase
  end

  // Access-phase wait counter; counts stalled cycles while forwarding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= '0;
    end else if (w_stall && !w_timeout) begin
      r_wait_cnt <= r_wait_cnt + WCW'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Sticky fault flag, entry pulse, captured address and saturating count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fault      <= 1'b0;
      r_irq        <= 1'b0;
      r_fault_addr <= '0;
      r_fault_cnt  <= '0;
    end else begin
      r_irq <= w_timeout;
      if (w_timeout) begin
        r_fault      <= 1'b1;
        r_fault_addr <= S_APB_PADDR;
        if (r_fault_cnt != 8'hFF) r_fault_cnt <= r_fault_cnt + 8'd1;
      end else if ((r_state == FAULT) && (w_state_nxt != FAULT)) begin
        r_fault <= 1'b0;
      end
    end
  end

  assign fault_o      = r_fault;
  assign irq_o        = r_irq;
  assign fault_addr_o = r_fault_addr;
  assign fault_cnt_o  = r_fault_cnt;

endmodule

// File: tb/tb_apb_ss_guard.sv
// Scoreboard bench for apb_ss_guard: the APB master task queues the expected
// completion, a negedge monitor pops and compares when S_PREADY completes.
module tb_apb_ss_guard;

  localparam logic [31:0] ERR = 32'hBADC_0DE5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] S_PADDR = '0;
  logic        S_PSEL = 1'b0;
  logic        S_PENABLE = 1'b0;
  logic        S_PWRITE = 1'b0;
  logic [31:0] S_PWDATA = '0;
  logic [3:0]  S_PSTRB = '0;
  logic [31:0] S_PRDATA;
  logic        S_PREADY;
  logic        S_PSLVERR;
  logic [31:0] M_PADDR;
  logic        M_PSEL;
  logic        M_PENABLE;
  logic        M_PWRITE;
  logic [31:0] M_PWDATA;
  logic [3:0]  M_PSTRB;
  logic [31:0] M_PRDATA;
  logic        M_PREADY;
  logic        M_PSLVERR;
  logic [6:0]  ss_ctrl = '0;
  logic        fault_o;
  logic        irq_o;
  logic [31:0] fault_addr_o;
  logic [7:0]  fault_cnt_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cycles;
  } exp_t;
  exp_t exp_q[$];

  // Subsystem model: PREADY after sub_waits wait states.
  int          sub_waits = 0;
  int          sub_acc = 0;
  logic [31:0] sub_rdata = 32'hCAFE_0001;
  logic        sub_err = 1'b0;

  assign M_PREADY  = (sub_acc == sub_waits);
  assign M_PRDATA  = sub_rdata;
  assign M_PSLVERR = sub_err;

  always @(posedge clk) begin
    if (M_PSEL && M_PENABLE && !M_PREADY) sub_acc <= sub_acc + 1;
    else                                  sub_acc <= 0;
  end

  always #5 clk = ~clk;

  apb_ss_guard #(
    .APB_AW(32), .APB_DW(32), .SS_CTRL_W(7), .TIMEOUT_CYC(16), .ERR_RDATA(ERR)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .S_APB_PADDR(S_PADDR), .S_APB_PSEL(S_PSEL), .S_APB_PENABLE(S_PENABLE),
    .S_APB_PWRITE(S_PWRITE), .S_APB_PWDATA(S_PWDATA), .S_APB_PSTRB(S_PSTRB),
    .S_APB_PRDATA(S_PRDATA), .S_APB_PREADY(S_PREADY), .S_APB_PSLVERR(S_PSLVERR),
    .M_APB_PADDR(M_PADDR), .M_APB_PSEL(M_PSEL), .M_APB_PENABLE(M_PENABLE),
    .M_APB_PWRITE(M_PWRITE), .M_APB_PWDATA(M_PWDATA), .M_APB_PSTRB(M_PSTRB),
    .M_APB_PRDATA(M_PRDATA), .M_APB_PREADY(M_PREADY), .M_APB_PSLVERR(M_PSLVERR),
    .ss_ctrl_i(ss_ctrl), .fault_o(fault_o), .irq_o(irq_o),
    .fault_addr_o(fault_addr_o), .fault_cnt_o(fault_cnt_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: idle response must be zero; each completion pops one expectation.
  initial begin
    int acc;
    exp_t e;
    acc = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        acc = 0;
      end else if (!S_PSEL) begin
        chk("idle_resp", {S_PRDATA[31:2], S_PREADY | S_PRDATA[1], S_PSLVERR | S_PRDATA[0]}, 32'h0);
      end else if (S_PENABLE) begin
        acc++;
        if (S_PREADY) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_completion actual=1 expected=0 @%0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("prdata", S_PRDATA, e.rdata);
            chk("pslverr", 32'(S_PSLVERR), 32'(e.err));
            chk("access_cycles", 32'(acc), 32'(e.cycles));
          end
          acc = 0;
        end
      end
    end
  end

  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [31:0] erd, input logic eerr, input int ecyc);
    bit done;
    exp_t e;
    e.rdata = erd; e.err = eerr; e.cycles = ecyc;
    exp_q.push_back(e);
    @(posedge clk); #1;
    S_PADDR = addr; S_PWRITE = wr; S_PWDATA = wdata; S_PSTRB = 4'hF;
    S_PSEL = 1'b1; S_PENABLE = 1'b0;
    @(posedge clk); #1;
    S_PENABLE = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (S_PREADY) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL xfer_timeout actual=no_pready expected=pready addr=%0h", addr);
    end
    @(posedge clk); #1;
    S_PSEL = 1'b0; S_PENABLE = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fault", 32'(fault_o), 32'h0);
    chk("rst_irq", 32'(irq_o), 32'h0);
    chk("rst_faddr", fault_addr_o, 32'h0);
    chk("rst_fcnt", 32'(fault_cnt_o), 32'h0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 ss_ctrl = 7'b000_0001;

    // Enabled write mirrors onto the subsystem port
    fork
      apb_xfer(32'h0103_0004, 1'b1, 32'h0000_1234, 32'hCAFE_0001, 1'b0, 1);
      begin
        @(posedge clk); @(negedge clk); @(negedge clk);
        chk("m_psel", 32'(M_PSEL), 32'h1);
        chk("m_penable", 32'(M_PENABLE), 32'h1);
        chk("m_paddr", M_PADDR, 32'h0103_0004);
        chk("m_pwrite", 32'(M_PWRITE), 32'h1);
        chk("m_pwdata", M_PWDATA, 32'h0000_1234);
        chk("m_pstrb", 32'(M_PSTRB), 32'hF);
      end
    join
    chk("t1_fault", 32'(fault_o), 32'h0);

    // Disabled: blocked read, zero-wait error
    #1 ss_ctrl = 7'b000_0000;
    fork
      apb_xfer(32'h0103_0000, 1'b0, 32'h0, ERR, 1'b1, 1);
      begin
        @(posedge clk); @(negedge clk); @(negedge clk);
        chk("blk_m_psel", 32'(M_PSEL), 32'h0);
      end
    join

    // Hung subsystem: abort on access cycle 16
    ss_ctrl = 7'b000_0001;
    sub_waits = 16;
    sub_rdata = 32'h7777_0010;
    apb_xfer(32'h0103_0010, 1'b0, 32'h0, ERR, 1'b1, 16);
    chk("to_fault", 32'(fault_o), 32'h1);
    chk("to_irq", 32'(irq_o), 32'h1);
    chk("to_faddr", fault_addr_o, 32'h0103_0010);
    chk("to_fcnt", 32'(fault_cnt_o), 32'h1);
    @(posedge clk); #1;
    chk("to_irq_pulse", 32'(irq_o), 32'h0);
    chk("to_fault_sticky", 32'(fault_o), 32'h1);
    sub_waits = 0;
    apb_xfer(32'h0103_0014, 1'b0, 32'h0, ERR, 1'b1, 1);

    // Clear pulse while idle with enable set
    ss_ctrl = 7'b000_0011;
    @(posedge clk); #1;
    chk("clr_fault", 32'(fault_o), 32'h0);
    ss_ctrl = 7'b000_0001;
    sub_rdata = 32'h5555_AAAA;
    apb_xfer(32'h0103_0020, 1'b0, 32'h0, 32'h5555_AAAA, 1'b0, 1);
    chk("clr_fcnt", 32'(fault_cnt_o), 32'h1);

    // PREADY on access cycle 16 completes normally; clear held high in PASS
    ss_ctrl = 7'b000_0011;
    sub_waits = 15;
    sub_rdata = 32'h1357_9BDF;
    apb_xfer(32'h0103_0030, 1'b0, 32'h0, 32'h1357_9BDF, 1'b0, 16);
    chk("edge_fault", 32'(fault_o), 32'h0);
    chk("edge_irq", 32'(irq_o), 32'h0);
    chk("edge_fcnt", 32'(fault_cnt_o), 32'h1);
    chk("edge_faddr", fault_addr_o, 32'h0103_0010);
    ss_ctrl = 7'b000_0001;

    // Subsystem PSLVERR passes through
    sub_waits = 2;
    sub_err = 1'b1;
    sub_rdata = 32'h0000_00EE;
    apb_xfer(32'h0103_0050, 1'b1, 32'h0000_0055, 32'h0000_00EE, 1'b1, 3);
    sub_err = 1'b0;

    // Enable dropped mid-transfer: transfer finishes, next one blocked
    sub_waits = 5;
    sub_rdata = 32'hA5A5_0006;
    fork
      apb_xfer(32'h0103_0040, 1'b1, 32'hDEAD_BEEF, 32'hA5A5_0006, 1'b0, 6);
      begin
        repeat (3) @(posedge clk);
        #2 ss_ctrl = 7'b000_0000;
      end
    join
    fork
      apb_xfer(32'h0103_0044, 1'b0, 32'h0, ERR, 1'b1, 1);
      begin
        @(posedge clk); @(negedge clk); @(negedge clk);
        chk("dis_m_psel", 32'(M_PSEL), 32'h0);
      end
    join

    repeat (4) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

endmodule
